// File: rtl/counter_pkg.sv
// Shared definitions for the team's counter blocks: state encoding and default width.
package counter_pkg;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_RUN    = 1'b1;
    localparam int   CNT_WIDTH = 5;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN
    } cnt_state_t;

endpackage : counter_pkg

// File: rtl/five_bit_down_counter.sv
// Loadable down-counter with busy/done handshake; counts a loaded budget to zero,
// then idles or reloads the last loaded value.
module five_bit_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = CNT_WIDTH,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_enable,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    cnt_state_t       state;
    logic [WIDTH-1:0] reload_q;

    // FSM, count, reload and done registers; load outranks every other action.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            count    <= ZERO;
            reload_q <= ZERO;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                count    <= load_value;
                reload_q <= load_value;
                if (load_value != ZERO) begin
                    state <= S_RUN;
                    busy  <= 1'b1;
                end else begin
                    // Zero-length budget finishes immediately.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_RUN: begin
                        if (count_enable) begin
                            if (count == ONE) begin
                                done <= 1'b1;
                                if (AUTO_RELOAD) begin
                                    count <= reload_q;
                                end else begin
                                    count <= ZERO;
                                    state <= S_IDLE;
                                    busy  <= 1'b0;
                                end
                            end else if (count != ZERO) begin
                                count <= count - ONE;
                            end else begin
                                // RUN with a zero count is unreachable; fall back safely.
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            busy <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : five_bit_down_counter

// File: tb/tb_five_bit_down_counter.sv
// Bench for five_bit_down_counter: one-shot and auto-reload instances share stimulus
// and are compared every cycle against a budget-level reference model.
module tb_five_bit_down_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_value = 5'd0;
    logic       count_enable = 1'b0;

    logic [4:0] count0, count1;
    logic       busy0, busy1, done0, done1;

    int checks = 0;
    int failures = 0;

    // Reference model state, index 0 = one-shot, 1 = auto-reload.
    int m_cnt [2] = '{0, 0};
    int m_rel [2] = '{0, 0};
    bit m_busy[2] = '{1'b0, 1'b0};
    bit m_done[2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    five_bit_down_counter #(.WIDTH(5), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .count_enable(count_enable), .count(count0), .busy(busy0), .done(done0)
    );

    five_bit_down_counter #(.WIDTH(5), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .count_enable(count_enable), .count(count1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Remaining-budget model: a loaded budget ticks down once per enabled cycle.
    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_cnt[i] = 0; m_rel[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
            end else if (load) begin
                m_cnt[i]  = int'(load_value);
                m_rel[i]  = int'(load_value);
                m_busy[i] = (load_value != 5'd0);
                m_done[i] = (load_value == 5'd0);
            end else if (m_busy[i] && count_enable) begin
                m_done[i] = (m_cnt[i] == 1);
                if (m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
                else if (i == 1) m_cnt[i] = m_rel[i];
                else begin m_cnt[i] = 0; m_busy[i] = 1'b0; end
            end else begin
                m_done[i] = 1'b0;
            end
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        check("cmp_count0", int'(count0), m_cnt[0]);
        check("cmp_busy0",  int'(busy0),  int'(m_busy[0]));
        check("cmp_done0",  int'(done0),  int'(m_done[0]));
        check("cmp_count1", int'(count1), m_cnt[1]);
        check("cmp_busy1",  int'(busy1),  int'(m_busy[1]));
        check("cmp_done1",  int'(done1),  int'(m_done[1]));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n, dones, e;

        // Reset held with random activity on the control inputs.
        for (int k = 0; k < 10; k++) begin
            load = 1'($urandom); count_enable = 1'($urandom); load_value = 5'($urandom);
            tick();
            check("rst_count", int'(count0), 0);
            check("rst_busy",  int'(busy0),  0);
            check("rst_done",  int'(done0),  0);
        end
        load = 1'b0; count_enable = 1'b0; reset = 1'b1;
        tick();
        check("post_rst_busy", int'(busy0), 0);
        check("post_rst_count", int'(count0), 0);

        // Load 5, enable continuously: 5,4,3,2,1,0.
        load = 1'b1; load_value = 5'd5;
        tick();
        check("ld5_count", int'(count0), 5);
        check("ld5_busy", int'(busy0), 1);
        load = 1'b0; count_enable = 1'b1;
        for (int k = 4; k >= 0; k--) begin
            tick();
            check("dn5_count", int'(count0), k);
            check("dn5_done", int'(done0), (k == 0) ? 1 : 0);
            check("dn5_busy", int'(busy0), (k != 0) ? 1 : 0);
        end
        count_enable = 1'b0;
        tick();
        check("dn5_done_width", int'(done0), 0);

        // Load 31 with the enable toggling: 61 cycles to zero, one done pulse.
        load = 1'b1; load_value = 5'd31;
        tick();
        load = 1'b0; n = 0; dones = 0;
        while (n < 100 && count0 != 5'd0) begin
            count_enable = (n % 2 == 0);
            tick();
            n++;
            if (done0) dones++;
        end
        check("ld31_cycles", n, 61);
        count_enable = 1'b0;
        tick();
        if (done0) dones++;
        check("ld31_dones", dones, 1);

        // Auto-reload instance: 3,2,1,3,2,1 with done on each reload.
        load = 1'b1; load_value = 5'd3; count_enable = 1'b1;
        tick();
        check("ar_count", int'(count1), 3);
        load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            e = (k % 3 == 0) ? 2 : ((k % 3 == 1) ? 1 : 3);
            tick();
            check("ar_count", int'(count1), e);
            check("ar_done", int'(done1), (e == 3) ? 1 : 0);
            check("ar_busy", int'(busy1), 1);
        end
        count_enable = 1'b0;

        // Zero-length load.
        load = 1'b1; load_value = 5'd0;
        tick();
        load = 1'b0;
        check("ld0_count", int'(count0), 0);
        check("ld0_busy", int'(busy0), 0);
        check("ld0_done", int'(done0), 1);
        tick();
        check("ld0_done_drop", int'(done0), 0);

        // Load on the terminal edge wins and suppresses done.
        load = 1'b1; load_value = 5'd2;
        tick();
        load = 1'b0; count_enable = 1'b1;
        tick();
        check("term_pre_count", int'(count0), 1);
        load = 1'b1; load_value = 5'd9;
        tick();
        load = 1'b0; count_enable = 1'b0;
        check("term_ld_count", int'(count0), 9);
        check("term_ld_done", int'(done0), 0);
        check("term_ld_busy", int'(busy0), 1);
        check("term_ld_done1", int'(done1), 0);

        // Asynchronous reset mid-count at 12.
        load = 1'b1; load_value = 5'd20;
        tick();
        load = 1'b0; count_enable = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("arst_pre_count", int'(count0), 12);
        reset = 1'b0;
        #1;
        check("arst_count", int'(count0), 0);
        check("arst_busy", int'(busy0), 0);
        check("arst_done", int'(done0), 0);
        tick();
        reset = 1'b1; count_enable = 1'b0;
        tick();

        // Randomized traffic, including occasional reset pulses.
        for (int k = 0; k < 3000; k++) begin
            load = ($urandom_range(7) == 0);
            load_value = ($urandom_range(3) == 0) ? 5'($urandom_range(3)) : 5'($urandom);
            count_enable = ($urandom_range(3) != 0);
            reset = ($urandom_range(99) != 0);
            tick();
        end
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_five_bit_down_counter

// File: doc/five_bit_down_counter.md
# five_bit_down_counter

Loadable 5-bit down-counter with a busy/done handshake; the counting-down complement of the team's `five_bit_counter`. A controller loads a cycle budget and the block decrements it on each enabled cycle. At zero it pulses `done` and either idles or reloads. It serves as the countdown timer in the controller datapaths, for example for iteration budgets and wait states.

## Interface
- `WIDTH`, 5: counter width in bits; all values are unsigned.
- `AUTO_RELOAD`, 0: when 1, the counter reloads the last loaded value on reaching zero instead of idling.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `load`  in  1: load request, sampled on the rising edge.
- `load_value`  in  WIDTH: start value, sampled when `load`=1.
- `count_enable`  in  1: decrement enable; honoured only in RUN.
- `count`  out  WIDTH: current counter value, registered.
- `busy`  out  1: high while in RUN, registered.
- `done`  out  1: one-cycle terminal-count pulse, registered.

## Operation
- Internal state: FSM {IDLE, RUN}, plus a WIDTH-bit reload register `reload_q`.
- Reset: `count`=0, `reload_q`=0, `busy`=0, `done`=0, state IDLE. Applies immediately and asynchronously, including mid-count.
- Load has priority over everything else, in any state:
  - `count` ← `load_value` and `reload_q` ← `load_value`.
  - If `load_value`≠0: state RUN.
  - If `load_value`=0: state IDLE and `done`=1 on the next cycle (zero-length budget).
- IDLE: `count` holds and `count_enable` is ignored.
- RUN with `count_enable`=1 and `count`>1: `count` ← `count`−1.
- RUN with `count_enable`=1 and `count`=1 (terminal edge):
  - `AUTO_RELOAD`=0: `count` ← 0, state IDLE, `done`=1 for exactly the following cycle.
  - `AUTO_RELOAD`=1: `count` ← `reload_q`, state RUN, `done`=1 for the following cycle. This is a wrap-around with no zero cycle visible on `count`.
- RUN with `count_enable`=0: everything holds; `done` stays 0.
- `count` never decrements below 0 and never wraps to 2^WIDTH−1.
- `load` on the terminal edge: the load wins, `done` is not asserted, and the new value is taken.
- `busy` = (state==RUN), registered, so it changes on the same edge as the state.

## Timing
- Load latency: `load` sampled at edge E; from E onward `count`=`load_value` and `busy`=1 (if `load_value` is nonzero).
- Load N (1..31), then hold `count_enable`=1 starting the cycle after the load edge: `count` shows N, N−1, …, 1, 0 on successive cycles. `done`=1 in the same cycle `count` first shows 0, and `busy` falls on that same edge.
- `done` is always exactly one cycle wide.
- `done` never coincides with `busy`=1 unless `AUTO_RELOAD`=1.
- Back-to-back: `load` may be asserted in the cycle where `done`=1. The new count starts at the next edge and `done` drops.
- Throughput: one decrement per enabled cycle; no bubbles.

## Structure
- Shared package `counter_pkg` holds:
  - state encoding constants `ST_IDLE`=1'b0 and `ST_RUN`=1'b1;
  - default width constant `CNT_WIDTH`=5, shared with `five_bit_counter`.
- Single module: FSM, count register, reload register and done register. No sub-module is required.

## Test plan
- Hold `reset`=0 for 10 cycles with random `load` and `count_enable`, then release → `count`=0, `busy`=0, `done`=0 throughout, and the block is in IDLE after release.
- Load 5, then `count_enable`=1 continuously → `count` shows 5,4,3,2,1,0; `done` is high only in the cycle showing 0; `busy` is high for 5 cycles.
- Load 31 with `count_enable` toggling 1/0 every cycle → `count` decrements only on enabled cycles; reaches 0 after 31 enabled edges (61 cycles); `done` is a single pulse.
- `AUTO_RELOAD`=1, load 3, enable held high → `count` shows 3,2,1,3,2,1…; `done` pulses every 3 cycles; `busy` stays 1.
- Load 0 → `count`=0, `busy`=0, `done` pulses once. Separately, load 9 on the terminal edge of a count-to-1 → no `done`, and `count`=9.
- Assert `reset` asynchronously mid-count at `count`=12 → `count`=0 and `busy`=0 immediately, with no `done`.
